// File: rtl/datetime_set_fsm_pkg.sv
// Shared types and clamp rules for the date/time setting controller.
// All functions are pure combinational helpers; no state lives here.
package dt_set_pkg;

    localparam int YEAR_W  = 7;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_YEAR    = 3'd1,
        ST_MONTH   = 3'd2,
        ST_DAY     = 3'd3,
        ST_HOUR    = 3'd4,
        ST_MIN     = 3'd5,
        ST_SEC     = 3'd6,
        ST_CONFIRM = 3'd7
    } state_e;

    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MIN_W-1:0]   min;
        logic [SEC_W-1:0]   sec;
    } dt_t;

    // Year 0 means 2000, so the reset date falls in a leap year.
    localparam dt_t DT_RESET = '{year: 7'd0, month: 4'd1, day: 5'd1,
                                 hour: 5'd0, min: 6'd0, sec: 6'd0};

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [6:0] year,
                                                 input logic       year_en);
        logic [4:0] d;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:    d = (year_en && (year[1:0] == 2'b00)) ? 5'd29 : 5'd28;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

    function automatic logic [6:0] clamp_year(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    function automatic logic [3:0] clamp_month(input logic [6:0] v);
        if (v == 7'd0) return 4'd1;
        if (v > 7'd12) return 4'd12;
        return v[3:0];
    endfunction

    function automatic logic [4:0] clamp_day(input logic [6:0] v,
                                             input logic [3:0] month,
                                             input logic [6:0] year,
                                             input logic       year_en);
        logic [4:0] dim;
        dim = days_in_month(month, year, year_en);
        if (v == 7'd0) return 5'd1;
        if (v > {2'b00, dim}) return dim;
        return v[4:0];
    endfunction

    function automatic logic [4:0] clamp_hour(input logic [6:0] v);
        return (v > 7'd23) ? 5'd23 : v[4:0];
    endfunction

    function automatic logic [5:0] clamp_min_sec(input logic [6:0] v);
        return (v > 7'd59) ? 6'd59 : v[5:0];
    endfunction

endpackage

// File: rtl/datetime_set_fsm_if.sv
// Button/switch inputs, live-time seed, preview and committed-time bundle.
// master = driver of buttons and live time; slave = the setting controller.
interface datetime_set_fsm_if #(
    parameter int SW_W = 7
);
    logic            start;
    logic            ent;
    logic            ret;
    logic            bstep;
    logic            inhibit;
    logic [SW_W-1:0] sw;
    logic [6:0]      cur_year;
    logic [3:0]      cur_month;
    logic [4:0]      cur_day;
    logic [4:0]      cur_hour;
    logic [5:0]      cur_min;
    logic [5:0]      cur_sec;

    logic            active;
    logic [2:0]      field;
    logic [6:0]      prv_year;
    logic [3:0]      prv_month;
    logic [4:0]      prv_day;
    logic [4:0]      prv_hour;
    logic [5:0]      prv_min;
    logic [5:0]      prv_sec;
    logic            blink;
    logic            set_done;
    logic [6:0]      out_year;
    logic [3:0]      out_month;
    logic [4:0]      out_day;
    logic [4:0]      out_hour;
    logic [5:0]      out_min;
    logic [5:0]      out_sec;

    modport master (
        output start, ent, ret, bstep, inhibit, sw,
               cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        input  active, field, blink, set_done,
               prv_year, prv_month, prv_day, prv_hour, prv_min, prv_sec,
               out_year, out_month, out_day, out_hour, out_min, out_sec
    );

    modport slave (
        input  start, ent, ret, bstep, inhibit, sw,
               cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        output active, field, blink, set_done,
               prv_year, prv_month, prv_day, prv_hour, prv_min, prv_sec,
               out_year, out_month, out_day, out_hour, out_min, out_sec
    );
endinterface

// File: rtl/datetime_set_fsm_clamp.sv
// Clamps the switch value to the legal range of the field being edited.
// Purely combinational; one copy feeds both the preview and the ent write path.
module dt_clamp
    import dt_set_pkg::*;
#(
    parameter bit YEAR_EN = 1'b1
) (
    input  state_e     field_i,
    input  logic [6:0] sw_i,
    input  logic [3:0] month_i,
    input  logic [6:0] year_i,
    output logic [6:0] val_o
);

    always_comb begin
        val_o = sw_i;
        case (field_i)
            ST_YEAR:        val_o = clamp_year(sw_i);
            ST_MONTH:       val_o = {3'b000, clamp_month(sw_i)};
            ST_DAY:         val_o = {2'b00, clamp_day(sw_i, month_i, year_i, YEAR_EN)};
            ST_HOUR:        val_o = {2'b00, clamp_hour(sw_i)};
            ST_MIN, ST_SEC: val_o = {1'b0, clamp_min_sec(sw_i)};
            default:        val_o = sw_i;
        endcase
    end

endmodule

// File: rtl/datetime_set_fsm.sv
// Manual date/time setting controller: stages edits, commits on CONFIRM, aborts on ret/timeout.
// Commit and state changes take effect one clock after the button pulse; no backpressure.
module datetime_set_fsm
    import dt_set_pkg::*;
#(
    parameter int          SW_W        = 7,
    parameter bit          YEAR_EN     = 1'b1,
    parameter logic [31:0] TIMEOUT_CYC = 32'd3_000_000_000,
    parameter int          BLINK_BIT   = 25
) (
    input logic               clk,
    input logic               rst,
    datetime_set_fsm_if.slave bus
);

    localparam state_e FIRST_FIELD = YEAR_EN ? ST_YEAR : ST_MONTH;

    state_e             state_q, state_d;
    dt_t                stg_q, stg_d;
    dt_t                out_q, out_d;
    logic               set_done_q, set_done_d;
    logic [31:0]        tmo_q, tmo_d;
    logic [BLINK_BIT:0] blink_q;
    logic               tmo_hit;
    logic [6:0]         clamp_val;
    dt_t                cur_dt;
    dt_t                prv;

    assign cur_dt = {bus.cur_year, bus.cur_month, bus.cur_day,
                     bus.cur_hour, bus.cur_min, bus.cur_sec};

    // Only the low 7 switch bits are meaningful; every field fits in 0..99.
    dt_clamp #(.YEAR_EN(YEAR_EN)) u_clamp (
        .field_i (state_q),
        .sw_i    (bus.sw[6:0]),
        .month_i (stg_q.month),
        .year_i  (stg_q.year),
        .val_o   (clamp_val)
    );

    // Abort fires on the edge where the idle count would reach TIMEOUT_CYC.
    assign tmo_hit = (TIMEOUT_CYC != 32'd0) && (tmo_q >= (TIMEOUT_CYC - 32'd1));

    always_comb begin
        state_d    = state_q;
        stg_d      = stg_q;
        out_d      = out_q;
        set_done_d = 1'b0;
        tmo_d      = (tmo_q == 32'hFFFF_FFFF) ? tmo_q : (tmo_q + 32'd1);

        if (state_q == ST_IDLE) begin
            tmo_d = 32'd0;
            if (bus.start && !bus.inhibit) begin
                stg_d   = cur_dt;
                state_d = FIRST_FIELD;
            end
        end else if (bus.ret) begin
            state_d = ST_IDLE;
        end else if (bus.bstep) begin
            tmo_d = 32'd0;
            case (state_q)
                ST_MONTH:   state_d = FIRST_FIELD;
                ST_DAY:     state_d = ST_MONTH;
                ST_HOUR:    state_d = ST_DAY;
                ST_MIN:     state_d = ST_HOUR;
                ST_SEC:     state_d = ST_MIN;
                ST_CONFIRM: state_d = ST_SEC;
                default:    state_d = state_q;
            endcase
        end else if (bus.ent && !bus.inhibit) begin
            tmo_d = 32'd0;
            case (state_q)
                ST_YEAR:  begin stg_d.year  = clamp_val;      state_d = ST_MONTH;   end
                ST_MONTH: begin stg_d.month = clamp_val[3:0]; state_d = ST_DAY;     end
                ST_DAY:   begin stg_d.day   = clamp_val[4:0]; state_d = ST_HOUR;    end
                ST_HOUR:  begin stg_d.hour  = clamp_val[4:0]; state_d = ST_MIN;     end
                ST_MIN:   begin stg_d.min   = clamp_val[5:0]; state_d = ST_SEC;     end
                ST_SEC:   begin stg_d.sec   = clamp_val[5:0]; state_d = ST_CONFIRM; end
                ST_CONFIRM: begin
                    // Month/year may have been re-edited after the day via bstep.
                    out_d      = stg_q;
                    out_d.day  = clamp_day({2'b00, stg_q.day}, stg_q.month, stg_q.year, YEAR_EN);
                    set_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = state_q;
            endcase
        end else if (tmo_hit) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        prv = stg_q;
        case (state_q)
            ST_IDLE:  prv       = out_q;
            ST_YEAR:  prv.year  = clamp_val;
            ST_MONTH: prv.month = clamp_val[3:0];
            ST_DAY:   prv.day   = clamp_val[4:0];
            ST_HOUR:  prv.hour  = clamp_val[4:0];
            ST_MIN:   prv.min   = clamp_val[5:0];
            ST_SEC:   prv.sec   = clamp_val[5:0];
            default:  prv       = stg_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stg_q      <= DT_RESET;
            out_q      <= DT_RESET;
            set_done_q <= 1'b0;
            tmo_q      <= 32'd0;
            blink_q    <= '0;
        end else begin
            state_q    <= state_d;
            stg_q      <= stg_d;
            out_q      <= out_d;
            set_done_q <= set_done_d;
            tmo_q      <= tmo_d;
            blink_q    <= blink_q + {{BLINK_BIT{1'b0}}, 1'b1};
        end
    end

    assign bus.active    = (state_q != ST_IDLE);
    assign bus.field     = state_q;
    assign bus.blink     = blink_q[BLINK_BIT] & (state_q != ST_IDLE);
    assign bus.set_done  = set_done_q;

    assign bus.prv_year  = prv.year;
    assign bus.prv_month = prv.month;
    assign bus.prv_day   = prv.day;
    assign bus.prv_hour  = prv.hour;
    assign bus.prv_min   = prv.min;
    assign bus.prv_sec   = prv.sec;

    assign bus.out_year  = out_q.year;
    assign bus.out_month = out_q.month;
    assign bus.out_day   = out_q.day;
    assign bus.out_hour  = out_q.hour;
    assign bus.out_min   = out_q.min;
    assign bus.out_sec   = out_q.sec;

endmodule
